// File: rtl/fsm_output_signature_monitor_if.sv
// Bus between the e17 output-signature monitor and whoever drives/reads it:
// window control, the monitored y vector, golden references and results.
interface fsm_output_signature_monitor_if #(
    parameter int WIDTH = 17,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] golden_sig;
    logic [CNT_W-1:0] golden_cnt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sig_out;
    logic [CNT_W-1:0] triple_cnt;
    logic             sig_err;
    logic             cnt_err;
    logic             mismatch;

    modport master (
        output start, y_in, golden_sig, golden_cnt,
        input  busy, done, sig_out, triple_cnt, sig_err, cnt_err, mismatch
    );

    modport slave (
        input  start, y_in, golden_sig, golden_cnt,
        output busy, done, sig_out, triple_cnt, sig_err, cnt_err, mismatch
    );
endinterface

// File: rtl/fsm_output_signature_monitor.sv
// Output-signature monitor for the locked e17 controller.
// Compacts y1..y17 over a fixed window into a MISR signature and counts the
// cycles where y1/y8/y9 are jointly high (the triple a wrong key suppresses).
// Both results are compared against golden values when the window closes.
module fsm_output_signature_monitor #(
    parameter int               WIDTH   = 17,
    parameter int               WIN_LEN = 64,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] POLY    = 17'h00009,
    parameter int               WIN_W   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    fsm_output_signature_monitor_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    logic [WIDTH-1:0] r_misr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIN_W-1:0] r_win;
    logic             r_busy;
    logic             r_done;
    logic             r_sig_err;
    logic             r_cnt_err;
    logic             r_mismatch;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_misr_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIN_W-1:0] w_win_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic             w_sig_err_next;
    logic             w_cnt_err_next;
    logic             w_mismatch_next;

    logic [WIDTH-1:0] w_misr_upd;
    logic [CNT_W-1:0] w_cnt_upd;
    logic             w_triple;
    logic             w_sig_err_fin;
    logic             w_cnt_err_fin;

    // One RUN-step of the MISR and the saturating triple counter.
    always_comb begin
        w_triple      = bus.y_in[0] & bus.y_in[7] & bus.y_in[8];
        w_misr_upd    = {r_misr[WIDTH-2:0], 1'b0}
                      ^ (r_misr[WIDTH-1] ? POLY : {WIDTH{1'b0}})
                      ^ bus.y_in;
        if (w_triple && (r_cnt != CNT_MAX)) begin
            w_cnt_upd = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_upd = r_cnt;
        end
        // Compared against the final values so the flags land with DONE.
        w_sig_err_fin = (w_misr_upd != bus.golden_sig);
        w_cnt_err_fin = (w_cnt_upd  != bus.golden_cnt);
    end

    // Next-state and next-output logic of the IDLE/RUN/DONE controller.
    always_comb begin
        w_state_next    = r_state;
        w_misr_next     = r_misr;
        w_cnt_next      = r_cnt;
        w_win_next      = r_win;
        w_busy_next     = r_busy;
        w_done_next     = r_done;
        w_sig_err_next  = r_sig_err;
        w_cnt_err_next  = r_cnt_err;
        w_mismatch_next = r_mismatch;
        case (r_state)
            S_IDLE, S_DONE: begin
                // A new window clears everything; y_in is not sampled here.
                if (bus.start) begin
                    w_state_next    = S_RUN;
                    w_misr_next     = {WIDTH{1'b0}};
                    w_cnt_next      = {CNT_W{1'b0}};
                    w_win_next      = {WIN_W{1'b0}};
                    w_busy_next     = 1'b1;
                    w_done_next     = 1'b0;
                    w_sig_err_next  = 1'b0;
                    w_cnt_err_next  = 1'b0;
                    w_mismatch_next = 1'b0;
                end else begin
                    w_state_next    = r_state;
                end
            end
            S_RUN: begin
                w_misr_next = w_misr_upd;
                w_cnt_next  = w_cnt_upd;
                if (r_win == WIN_LAST) begin
                    w_state_next    = S_DONE;
                    w_win_next      = {WIN_W{1'b0}};
                    w_busy_next     = 1'b0;
                    w_done_next     = 1'b1;
                    w_sig_err_next  = w_sig_err_fin;
                    w_cnt_err_next  = w_cnt_err_fin;
                    w_mismatch_next = w_sig_err_fin | w_cnt_err_fin;
                end else begin
                    w_win_next      = r_win + {{(WIN_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_next    = S_IDLE;
                w_misr_next     = {WIDTH{1'b0}};
                w_cnt_next      = {CNT_W{1'b0}};
                w_win_next      = {WIN_W{1'b0}};
                w_busy_next     = 1'b0;
                w_done_next     = 1'b0;
                w_sig_err_next  = 1'b0;
                w_cnt_err_next  = 1'b0;
                w_mismatch_next = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any window immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_misr     <= {WIDTH{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_win      <= {WIN_W{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sig_err  <= 1'b0;
            r_cnt_err  <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_misr     <= w_misr_next;
            r_cnt      <= w_cnt_next;
            r_win      <= w_win_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_sig_err  <= w_sig_err_next;
            r_cnt_err  <= w_cnt_err_next;
            r_mismatch <= w_mismatch_next;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.sig_out    = r_misr;
    assign bus.triple_cnt = r_cnt;
    assign bus.sig_err    = r_sig_err;
    assign bus.cnt_err    = r_cnt_err;
    assign bus.mismatch   = r_mismatch;

endmodule

// File: tb/tb_fsm_output_signature_monitor.sv
// Directed bench for fsm_output_signature_monitor: three instances with
// window lengths 64, 4 and 300 share clock, reset, y vector and goldens.
module tb_fsm_output_signature_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] y = 17'h00000;
    logic [16:0] golden_sig = 17'h00000;
    logic [7:0]  golden_cnt = 8'h00;
    logic        start64 = 1'b0;
    logic        start4 = 1'b0;
    logic        start300 = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc;
    logic [16:0] exp_sig;

    fsm_output_signature_monitor_if #(.WIDTH(17), .CNT_W(8)) if64 ();
    fsm_output_signature_monitor_if #(.WIDTH(17), .CNT_W(8)) if4 ();
    fsm_output_signature_monitor_if #(.WIDTH(17), .CNT_W(8)) if300 ();

    assign if64.start       = start64;
    assign if64.y_in        = y;
    assign if64.golden_sig  = golden_sig;
    assign if64.golden_cnt  = golden_cnt;
    assign if4.start        = start4;
    assign if4.y_in         = y;
    assign if4.golden_sig   = golden_sig;
    assign if4.golden_cnt   = golden_cnt;
    assign if300.start      = start300;
    assign if300.y_in       = y;
    assign if300.golden_sig = golden_sig;
    assign if300.golden_cnt = golden_cnt;

    fsm_output_signature_monitor #(.WIN_LEN(64)) u64 (.clk(clk), .rst(rst), .bus(if64.slave));
    fsm_output_signature_monitor #(.WIN_LEN(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    fsm_output_signature_monitor #(.WIN_LEN(300)) u300 (.clk(clk), .rst(rst), .bus(if300.slave));

    always #5 clk = ~clk;

    // Reference signature: sample j (1-based) is base, or base without y9 for j in [lo,hi].
    function automatic logic [16:0] model_sig(input logic [16:0] base, input int lo, input int hi, input int n);
        logic [16:0] m;
        logic [16:0] v;
        logic        carry;
        m = 17'h00000;
        for (int j = 1; j <= n; j++) begin
            v = base;
            if (j >= lo && j <= hi) v[8] = 1'b0;
            carry = m[16];
            m = {m[15:0], 1'b0};
            if (carry) m = m ^ 17'h00009;
            m = m ^ v;
        end
        return m;
    endfunction

    task automatic do_start(input int which);
        if (which == 64) start64 = 1'b1;
        else if (which == 4) start4 = 1'b1;
        else start300 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        start4 = 1'b0;
        start300 = 1'b0;
    endtask

    // Drive one 64-sample window on u64 and count negedges with busy high.
    task automatic run_win64(input logic [16:0] base, input int lo, input int hi, input int restart_at, output int n);
        n = 0;
        while (if64.busy === 1'b1 && n < 200) begin
            y = base;
            if (n + 1 >= lo && n + 1 <= hi) y[8] = 1'b0;
            start64 = (n == restart_at);
            @(negedge clk);
            n++;
        end
        start64 = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (if64.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", if64.busy); end
        n_cmp++; if (if64.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", if64.done); end
        n_cmp++; if (if64.sig_out !== 17'h00000) begin n_err++; $display("FAIL reset_sig got %h want 0", if64.sig_out); end
        n_cmp++; if (if64.triple_cnt !== 8'h00) begin n_err++; $display("FAIL reset_cnt got %0d want 0", if64.triple_cnt); end
        n_cmp++; if ({if64.sig_err, if64.cnt_err, if64.mismatch} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {if64.sig_err, if64.cnt_err, if64.mismatch}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_window;
        y = 17'h00000; golden_sig = 17'h00000; golden_cnt = 8'h00;
        do_start(64);
        run_win64(17'h00000, 0, -1, -1, cyc);
        n_cmp++; if (cyc !== 64) begin n_err++; $display("FAIL zero_busy_cycles got %0d want 64", cyc); end
        n_cmp++; if (if64.done !== 1'b1) begin n_err++; $display("FAIL zero_done got %b want 1", if64.done); end
        n_cmp++; if (if64.sig_out !== 17'h00000) begin n_err++; $display("FAIL zero_sig got %h want 0", if64.sig_out); end
        n_cmp++; if (if64.triple_cnt !== 8'h00) begin n_err++; $display("FAIL zero_cnt got %0d want 0", if64.triple_cnt); end
        n_cmp++; if (if64.mismatch !== 1'b0) begin n_err++; $display("FAIL zero_mismatch got %b want 0", if64.mismatch); end
    endtask

    task automatic test_misr_short;
        logic [16:0] steps [4];
        steps[0] = 17'h00001; steps[1] = 17'h00003; steps[2] = 17'h00007; steps[3] = 17'h0000F;
        y = 17'h00001; golden_sig = 17'h0000F; golden_cnt = 8'h00;
        do_start(4);
        n_cmp++; if (if4.sig_out !== 17'h00000 || if4.busy !== 1'b1) begin n_err++; $display("FAIL misr_cleared got sig %h busy %b want 0/1", if4.sig_out, if4.busy); end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_cmp++; if (if4.sig_out !== steps[j]) begin n_err++; $display("FAIL misr_step%0d got %h want %h", j, if4.sig_out, steps[j]); end
        end
        n_cmp++; if (if4.done !== 1'b1 || if4.busy !== 1'b0) begin n_err++; $display("FAIL misr_done got done %b busy %b want 1/0", if4.done, if4.busy); end
        n_cmp++; if (if4.sig_err !== 1'b0 || if4.mismatch !== 1'b0) begin n_err++; $display("FAIL misr_match got %b%b want 00", if4.sig_err, if4.mismatch); end
        golden_sig = 17'h0000E;
        @(negedge clk);
        n_cmp++; if (if4.sig_err !== 1'b0) begin n_err++; $display("FAIL misr_flag_held got %b want 0", if4.sig_err); end
        do_start(4);
        repeat (4) @(negedge clk);
        n_cmp++; if (if4.sig_out !== 17'h0000F) begin n_err++; $display("FAIL misr_rerun_sig got %h want 0000f", if4.sig_out); end
        n_cmp++; if (if4.sig_err !== 1'b1 || if4.mismatch !== 1'b1) begin n_err++; $display("FAIL misr_err got %b%b want 11", if4.sig_err, if4.mismatch); end
    endtask

    task automatic test_triple;
        golden_cnt = 8'd64;
        exp_sig = model_sig(17'h00181, 0, -1, 64);
        golden_sig = exp_sig;
        y = 17'h00181;
        do_start(64);
        run_win64(17'h00181, 0, -1, -1, cyc);
        n_cmp++; if (if64.triple_cnt !== 8'd64) begin n_err++; $display("FAIL triple_full got %0d want 64", if64.triple_cnt); end
        n_cmp++; if (if64.sig_out !== exp_sig) begin n_err++; $display("FAIL triple_sig got %h want %h", if64.sig_out, exp_sig); end
        n_cmp++; if ({if64.sig_err, if64.cnt_err, if64.mismatch} !== 3'b000) begin n_err++; $display("FAIL triple_flags got %b want 000", {if64.sig_err, if64.cnt_err, if64.mismatch}); end
        exp_sig = model_sig(17'h00181, 5, 14, 64);
        golden_sig = exp_sig;
        do_start(64);
        run_win64(17'h00181, 5, 14, -1, cyc);
        n_cmp++; if (if64.triple_cnt !== 8'd54) begin n_err++; $display("FAIL triple_gaps got %0d want 54", if64.triple_cnt); end
        n_cmp++; if ({if64.sig_err, if64.cnt_err, if64.mismatch} !== 3'b011) begin n_err++; $display("FAIL triple_cnt_err got %b want 011", {if64.sig_err, if64.cnt_err, if64.mismatch}); end
    endtask

    task automatic test_saturate;
        y = 17'h00181; golden_cnt = 8'd255; golden_sig = 17'h00000;
        do_start(300);
        cyc = 0;
        while (if300.busy === 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cyc !== 300) begin n_err++; $display("FAIL sat_busy_cycles got %0d want 300", cyc); end
        n_cmp++; if (if300.triple_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cnt got %0d want 255", if300.triple_cnt); end
        n_cmp++; if (if300.done !== 1'b1 || if300.cnt_err !== 1'b0) begin n_err++; $display("FAIL sat_done got done %b cnt_err %b want 1/0", if300.done, if300.cnt_err); end
    endtask

    task automatic test_back_to_back;
        golden_cnt = 8'd0;
        exp_sig = model_sig(17'h00181, 0, -1, 64);
        golden_sig = exp_sig;
        y = 17'h00181;
        do_start(64);
        run_win64(17'h00181, 0, -1, 20, cyc);
        n_cmp++; if (cyc !== 64) begin n_err++; $display("FAIL restart_ignored_cycles got %0d want 64", cyc); end
        n_cmp++; if (if64.triple_cnt !== 8'd64) begin n_err++; $display("FAIL restart_ignored_cnt got %0d want 64", if64.triple_cnt); end
        n_cmp++; if (if64.cnt_err !== 1'b1 || if64.mismatch !== 1'b1) begin n_err++; $display("FAIL restart_err_set got %b%b want 11", if64.cnt_err, if64.mismatch); end
        do_start(64);
        n_cmp++; if (if64.done !== 1'b0 || if64.busy !== 1'b1) begin n_err++; $display("FAIL restart_state got done %b busy %b want 0/1", if64.done, if64.busy); end
        n_cmp++; if (if64.triple_cnt !== 8'd0 || if64.sig_out !== 17'h00000) begin n_err++; $display("FAIL restart_clear got cnt %0d sig %h want 0/0", if64.triple_cnt, if64.sig_out); end
        n_cmp++; if ({if64.sig_err, if64.cnt_err, if64.mismatch} !== 3'b000) begin n_err++; $display("FAIL restart_flags got %b want 000", {if64.sig_err, if64.cnt_err, if64.mismatch}); end
    endtask

    task automatic test_reset_abort;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (if64.busy !== 1'b0 || if64.done !== 1'b0) begin n_err++; $display("FAIL abort_state got busy %b done %b want 0/0", if64.busy, if64.done); end
        n_cmp++; if (if64.triple_cnt !== 8'd0 || if64.sig_out !== 17'h00000) begin n_err++; $display("FAIL abort_clear got cnt %0d sig %h want 0/0", if64.triple_cnt, if64.sig_out); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        golden_cnt = 8'd64;
        exp_sig = model_sig(17'h00181, 0, -1, 64);
        golden_sig = exp_sig;
        do_start(64);
        run_win64(17'h00181, 0, -1, -1, cyc);
        n_cmp++; if (cyc !== 64) begin n_err++; $display("FAIL abort_rerun_cycles got %0d want 64", cyc); end
        n_cmp++; if (if64.triple_cnt !== 8'd64 || if64.sig_out !== exp_sig) begin n_err++; $display("FAIL abort_rerun_result got cnt %0d sig %h want 64/%h", if64.triple_cnt, if64.sig_out, exp_sig); end
        n_cmp++; if (if64.mismatch !== 1'b0) begin n_err++; $display("FAIL abort_rerun_mismatch got %b want 0", if64.mismatch); end
    endtask

    initial begin
        test_reset;
        test_zero_window;
        test_misr_short;
        test_triple;
        test_saturate;
        test_back_to_back;
        test_reset_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_output_signature_monitor.md
Name: fsm_output_signature_monitor

Overview:
- Downstream consumer of the locked e17 controller's output vector y1..y17.
- Compacts the vector over a fixed window into a 17-bit MISR signature.
- Counts cycles in which the y1/y8/y9 triple is jointly asserted; this triple is the one a key-dependent payload suppresses.
- Compares both results against golden values so a bench or a test-mode controller can flag wrong-key or tampered behaviour.

Parameters:
- WIDTH, 17, width of the monitored output vector (y1 = bit 0 … y17 = bit 16).
- WIN_LEN, 64, number of sampled cycles per window (≥ 1).
- CNT_W, 8, width of the triple counter (saturating).
- POLY, 17'h00009, MISR feedback taps (x^17 + x^3 + 1).
- WIN_W, 16, width of the internal window counter (must hold WIN_LEN-1).

Ports:
- clk  in  1  clock; sampling on rising edge (the upstream FSM updates state on falling edge, so y is stable at the rising edge).
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a new window; honoured in IDLE or DONE only.
- y_in  in  WIDTH  upstream output vector {y17..y1}.
- golden_sig  in  WIDTH  expected signature.
- golden_cnt  in  CNT_W  expected triple count.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE; results valid.
- sig_out  out  WIDTH  current/final MISR value.
- triple_cnt  out  CNT_W  current/final triple count.
- sig_err  out  1  sig_out != golden_sig; valid while done.
- cnt_err  out  1  triple_cnt != golden_cnt; valid while done.
- mismatch  out  1  sig_err | cnt_err; valid while done.

Behaviour:
- Reset values: state IDLE, busy=0, done=0, sig_out=0, triple_cnt=0, sig_err=0, cnt_err=0, mismatch=0, window counter 0. Reset asserted mid-RUN aborts the window immediately; nothing is retained.
- States: IDLE, RUN, DONE (registered, rising edge).
- IDLE:
  - On start=1: go to RUN, clear MISR, triple count and window counter, set busy=1.
  - y_in is not sampled on the start edge.
- RUN, at each rising edge:
  - MISR update: misr_next = {misr[WIDTH-2:0],1'b0} ^ (misr[WIDTH-1] ? POLY : 0) ^ y_in.
  - Triple count: if y_in[0] & y_in[7] & y_in[8], triple_cnt increments, saturating at 2^CNT_W-1 (no wrap).
  - Window counter increments.
  - When the counter equals WIN_LEN-1 on an edge, that edge takes the final sample and moves to DONE.
  - start is ignored in RUN.
- Latency: start sampled at edge k. Samples are taken at edges k+1..k+WIN_LEN. DONE is entered at edge k+WIN_LEN.
- Entering DONE:
  - busy=0, done=1.
  - sig_err, cnt_err and mismatch are registered on the same edge from the final (next-state) values. No extra cycle of latency.
- DONE:
  - sig_out and triple_cnt are frozen.
  - Error flags are held; golden inputs changing after entry do not alter them.
  - Remains in DONE until start=1, which behaves exactly as in IDLE: clears everything and enters RUN on that edge, with done, error flags and mismatch cleared.
- sig_out and triple_cnt are visible live during RUN; error flags are 0 outside DONE.
- X on y_in is not tolerated; the bench drives known values.

Test Plan:
- Reset, start, y_in=0, WIN_LEN=64, goldens 0 → done at edge 64 after start; sig_out=0, triple_cnt=0, mismatch=0; busy high for exactly 64 cycles.
- WIN_LEN=4, y_in=17'h00001 constant → sig_out progresses 1,3,7,F; final sig_out=17'h0000F. golden_sig=17'h0000F gives sig_err=0; golden_sig=17'h0000E gives sig_err=1, mismatch=1.
- y_in=17'h00181 (y1,y8,y9) for 64 cycles → triple_cnt=64. Same run with bit 8 cleared on 10 of those cycles → triple_cnt=54. golden_cnt=64 gives cnt_err=1.
- WIN_LEN=300, CNT_W=8, y_in=17'h00181 → triple_cnt saturates at 255 with no wrap; done at edge 300.
- WIN_LEN=64, pulse start again at cycle 20 of RUN → ignored; done still at edge 64. Then start in DONE → done drops next edge and a fresh window begins with counters at 0.
- rst asserted at cycle 30 of RUN, asynchronous between edges → all outputs 0 immediately, state IDLE. A later start gives a full 64-cycle window unaffected by the aborted one.
